// File: rtl/div_pkg.sv
// Shared constants for the repeated-subtraction divider: default width and FSM encoding.
package div_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_LDA  = 3'b001,
    S_LDB  = 3'b010,
    S_SUB  = 3'b011,
    S_DONE = 3'b100
  } state_e;

endpackage

// File: rtl/div_datapath.sv
// Remainder/divisor/quotient registers with the guarded subtractor and >= comparator.
module div_datapath
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ld_r,
  input  logic             i_ld_d,
  input  logic             i_clr_q,
  input  logic             i_set_q,
  input  logic             i_step,
  output logic             o_ge,
  output logic             o_din_zero,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] w_diff;

  // Subtraction result is only used when o_ge holds, so it never underflows.
  assign w_diff     = r_rem - r_div;
  assign o_ge       = (r_rem >= r_div);
  assign o_din_zero = (i_data == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem <= '0;
      r_div <= '0;
      r_quo <= '0;
    end else begin
      if (i_ld_r)      r_rem <= i_data;
      else if (i_step) r_rem <= w_diff;

      if (i_ld_d) r_div <= i_data;

      if (i_set_q)      r_quo <= '1;
      else if (i_clr_q) r_quo <= '0;
      else if (i_step)  r_quo <= r_quo + ONE;
    end
  end

  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/div_repeated_sub.sv
// Unsigned repeated-subtraction divider: operands loaded over two cycles on data_in,
// one subtraction per cycle, level done flag with held result.
module div_repeated_sub
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  state_e r_state;
  logic   r_busy;
  logic   r_done;
  logic   r_dbz;

  logic   w_ld_r;
  logic   w_ld_d;
  logic   w_clr_q;
  logic   w_set_q;
  logic   w_step;
  logic   w_ge;
  logic   w_din_zero;

  assign w_ld_r  = (r_state == S_LDA);
  assign w_ld_d  = (r_state == S_LDB);
  assign w_clr_q = (r_state == S_LDB);
  assign w_set_q = (r_state == S_LDB) && w_din_zero;
  assign w_step  = (r_state == S_SUB) && w_ge;

  div_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk         (clk),
    .rst         (rst),
    .i_data      (data_in),
    .i_ld_r      (w_ld_r),
    .i_ld_d      (w_ld_d),
    .i_clr_q     (w_clr_q),
    .i_set_q     (w_set_q),
    .i_step      (w_step),
    .o_ge        (w_ge),
    .o_din_zero  (w_din_zero),
    .o_quotient  (quotient),
    .o_remainder (remainder)
  );

  // busy/done are registered alongside the state so they track it exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LDA;
            r_busy  <= 1'b1;
          end
        end
        S_LDA: r_state <= S_LDB;
        S_LDB: begin
          if (w_din_zero) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_dbz   <= 1'b1;
          end else begin
            r_state <= S_SUB;
          end
        end
        S_SUB: begin
          if (!w_ge) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          if (start) begin
            r_state <= S_LDA;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_dbz   <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_repeated_sub.sv
// Scoreboard bench for div_repeated_sub: driver pushes expected results, monitor checks on done.
`timescale 1ns/1ps
module tb_div_repeated_sub;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          lat;
    int          bcnt;
    int          e0;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  div_repeated_sub #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .data_in     (data_in),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: compares each completed result against the head of the scoreboard.
  initial begin
    exp_t e;
    int   bc;
    logic pd;
    bc = 0;
    pd = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bc = 0;
        pd = 1'b0;
      end else begin
        if (busy) bc++;
        if (done && !pd) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("quotient", int'(quotient), int'(e.q));
            chk("remainder", int'(remainder), int'(e.r));
            chk("div_by_zero", int'(div_by_zero), int'(e.dz));
            chk("latency", cyc - e.e0, e.lat);
            chk("busy_cycles", bc, e.bcnt);
          end
          bc = 0;
        end
        pd = done;
      end
    end
  end

  task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic edz, input bit pulse);
    exp_t e;
    @(negedge clk);
    start   = 1'b1;
    data_in = 16'($urandom);
    @(posedge clk);
    #1;
    e.q    = eq;
    e.r    = er;
    e.dz   = edz;
    e.lat  = edz ? 2 : 3 + int'(eq);
    e.bcnt = edz ? 2 : 3 + int'(eq);
    e.e0   = cyc;
    sb.push_back(e);
    @(negedge clk);
    start   = 1'b0;
    data_in = a;
    @(negedge clk);
    data_in = b;
    @(negedge clk);
    data_in = 16'($urandom);
    if (pulse) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 70000 && !done; i++) @(negedge clk);
    if (!done) chk("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
    chk("hold_done", int'(done), 1);
    chk("hold_quotient", int'(quotient), int'(eq));
    chk("hold_remainder", int'(remainder), int'(er));
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    run_div(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0);
    run_div(16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 1'b0);
    run_div(16'd0, 16'd3, 16'd0, 16'd0, 1'b0, 1'b0);
    run_div(16'd65535, 16'd65535, 16'd1, 16'd0, 1'b0, 1'b0);
    run_div(16'd42, 16'd0, 16'hFFFF, 16'd42, 1'b1, 1'b0);
    run_div(16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 1'b0);
    run_div(16'd65535, 16'd1, 16'd65535, 16'd0, 1'b0, 1'b0);

    // Reset in the middle of 1000 / 3
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    data_in = 16'd1000;
    @(negedge clk);
    data_in = 16'd3;
    repeat (10) @(negedge clk);
    chk("mid_sub_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("midrst_quotient", int'(quotient), 0);
    chk("midrst_remainder", int'(remainder), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_dbz", int'(div_by_zero), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_div(16'd20, 16'd6, 16'd3, 16'd2, 1'b0, 1'b0);
    run_div(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_repeated_sub.md
Name: div_repeated_sub

Overview:
- Unsigned integer divider using repeated subtraction: the division counterpart of the repeated-addition multiplier.
- Operands arrive on one shared data_in bus over two consecutive cycles, dividend first, then divisor, under FSM control.
- Subtracts the divisor from a remainder register once per cycle, incrementing the quotient each time, until remainder < divisor.
- Reports the result with a level done flag.

Parameters:
- WIDTH, 16, operand/result bit width (dividend, divisor, quotient, remainder).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin operation; sampled only in IDLE or DONE
- data_in  input  WIDTH  dividend in LDA cycle, divisor in LDB cycle
- quotient  output  WIDTH  registered quotient, valid while done=1
- remainder  output  WIDTH  registered remainder, valid while done=1
- busy  output  1  high in LDA, LDB, SUB
- done  output  1  high in DONE
- div_by_zero  output  1  high in DONE when captured divisor was 0

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - quotient, remainder and divisor register = 0.
  - busy=0, done=0, div_by_zero=0.
- States: IDLE, LDA, LDB, SUB, DONE. Outputs busy/done are decoded from state only (Moore); no delays in RTL.
- IDLE: start=1 at edge E0 -> LDA. Otherwise stay.
- LDA: at edge E1, remainder<=data_in (dividend) -> LDB. Unconditional.
- LDB: at edge E2:
  - divisor<=data_in; quotient<=0.
  - If data_in==0: quotient<=all ones, div_by_zero<=1 -> DONE. Remainder keeps the dividend.
  - Else -> SUB.
- SUB: at each edge:
  - If remainder >= divisor: remainder<=remainder-divisor, quotient<=quotient+1, stay in SUB.
  - Else -> DONE, registers unchanged.
- Latency: for quotient q, SUB occupies q+1 cycles; done first visible after edge E(3+q). Divide-by-zero: done visible after E2.
- Arithmetic:
  - Compare and subtract are unsigned, full WIDTH.
  - Subtraction never underflows because it is guarded by >=.
  - Quotient cannot exceed 2^WIDTH-1 (divisor>=1), so no wrap.
- DONE:
  - done=1; quotient, remainder and div_by_zero are held stable indefinitely.
  - start=1 -> LDA; div_by_zero cleared on that edge.
- start while busy: ignored, no effect on the operation in progress.
- data_in is don't-care outside LDA/LDB.
- During LDA/LDB, quotient and remainder are not valid: remainder is overwritten at E1, quotient at E2.
- Reset mid-operation:
  - Immediate return to IDLE with all outputs 0.
  - The partial result is discarded.
  - The next start behaves as from power-up.

Decomposition:
- Shared package div_pkg:
  - State encoding constants S_IDLE=3'b000, S_LDA=3'b001, S_LDB=3'b010, S_SUB=3'b011, S_DONE=3'b100.
  - Default WIDTH constant.
- One sub-module, div_datapath, holding:
  - remainder, divisor and quotient registers with load/clear/enable controls;
  - the subtractor;
  - the >= comparator, exporting ge and divisor-zero flags.
- Top level holds the FSM and drives the datapath controls (ldR, ldD, clrQ, setQ, step).

Test Plan:
- Basic division: start pulse, then data_in=100 (LDA), 7 (LDB) -> quotient=14, remainder=2, div_by_zero=0; done rises after edge E17 (3+14) and holds.
- Dividend < divisor: 5 / 9 -> quotient=0, remainder=5; done after E3; busy high for exactly 3 cycles (LDA, LDB, SUB).
- Edge cases:
  - 0 / 3 -> 0, 0.
  - 65535 / 1 -> quotient=65535, remainder=0, done after E65538.
  - 65535 / 65535 -> 1, 0.
- Divide by zero: 42 / 0 -> div_by_zero=1, quotient=16'hFFFF, remainder=42, done after E2. Then a new start with 9 / 3 -> quotient=3, remainder=0, div_by_zero cleared.
- Reset and start during operation:
  - Assert rst mid-SUB during 1000 / 3 -> all outputs 0 immediately, state IDLE.
  - Then 20 / 6 -> quotient=3, remainder=2.
  - Pulsing start while busy leaves the result unchanged.
